// File: rtl/stream_pkg.sv
// Shared definitions for the stream arbitration blocks: state encoding and
// the ID-width helper used to size source index fields.
package stream_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Width of a source index; a single source still gets a 1-bit field.
    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: rotate the request vector so 'base' sits at
// bit 0, take the lowest set bit, then map the offset back to a source index.
module rr_priority_picker
    import stream_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = idw(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] base,
    output logic           any,
    output logic [IDW-1:0] winner
);

    localparam int SW = IDW + 1;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    logic [SW-1:0]  sum;

    always_comb begin
        any = |req;
        dbl = {req, req} >> base;
        rot = dbl[N-1:0];
        off = '0;
        // Descending scan so the lowest set bit (closest to base) wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
        sum = SW'(base) + SW'(off);
        if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
        end
        winner = sum[IDW-1:0];
    end

endmodule

// File: rtl/stream_arbiter_rr.sv
// Packet-granular round-robin arbiter sharing one stream consumer between
// N_SRC requesters; the granted source is passed through combinationally.
module stream_arbiter_rr
    import stream_pkg::*;
#(
    parameter int  N_SRC     = 2,
    parameter int  DW        = 32,
    parameter int  MAX_BEATS = 256,
    localparam int IDW       = idw(N_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC*DW-1:0] s_data_i,
    input  logic [N_SRC-1:0]  s_valid_i,
    input  logic [N_SRC-1:0]  s_last_i,
    output logic [N_SRC-1:0]  s_ready_o,
    output logic [DW-1:0]     m_data_o,
    output logic              m_valid_o,
    output logic              m_last_o,
    output logic [IDW-1:0]    m_id_o,
    input  logic              m_ready_i,
    output logic              busy_o
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_t     state, state_nxt;
    logic [IDW-1:0] grant, last_grant, base, winner;
    logic [CW-1:0]  beat_cnt;
    logic           any, active, cap_hit, beat, final_beat;
    logic [DW-1:0]  g_data;
    logic           g_valid, g_last;

    assign base = (last_grant == IDW'(N_SRC - 1)) ? '0 : last_grant + IDW'(1);

    rr_priority_picker #(
        .N   (N_SRC),
        .IDW (IDW)
    ) u_picker (
        .req    (s_valid_i),
        .base   (base),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake: a beat transfers when m_valid_o & m_ready_i; the granted
    // source sees m_ready_i on its s_ready_o, so source and consumer agree on
    // the same beat. Valid never depends on ready.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant == IDW'(k)) begin
                g_data  = s_data_i[k*DW +: DW];
                g_valid = s_valid_i[k];
                g_last  = s_last_i[k];
            end
        end

        active    = (state == ST_GRANT) && !rst;
        cap_hit   = (beat_cnt == CW'(MAX_BEATS - 1));
        m_data_o  = g_data;
        m_id_o    = grant;
        m_valid_o = active & g_valid;
        m_last_o  = active & (g_last | cap_hit);
        busy_o    = active;
        for (int k = 0; k < N_SRC; k++) begin
            s_ready_o[k] = active && (grant == IDW'(k)) && m_ready_i;
        end

        beat       = m_valid_o & m_ready_i;
        final_beat = beat & m_last_o;

        state_nxt = state;
        case (state)
            ST_IDLE:  if (any)        state_nxt = ST_GRANT;
            ST_GRANT: if (final_beat) state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= IDW'(N_SRC - 1);
            beat_cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (any) begin
                grant      <= winner;
                last_grant <= winner;
                beat_cnt   <= '0;
            end
        end else if (beat) begin
            // Cleared on the final beat so the counter never sits at the cap.
            beat_cnt <= final_beat ? '0 : beat_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Directed bench for stream_arbiter_rr: a 2-source default instance and a
// 3-source, 4-beat-cap instance share one source model and cycle vectors.
module tb_stream_arbiter_rr;

    logic          clk;
    logic          rst;
    logic [95:0]   s_data;
    logic [2:0]    s_valid;
    logic [2:0]    s_last;
    logic          m_ready;
    logic          sel;

    logic [1:0]    a_ready;
    logic [31:0]   a_data;
    logic          a_valid, a_last, a_busy;
    logic [0:0]    a_id;

    logic [2:0]    b_ready;
    logic [31:0]   b_data;
    logic          b_valid, b_last, b_busy;
    logic [1:0]    b_id;

    logic [2:0]    o_ready;
    logic [31:0]   o_data;
    logic          o_valid, o_last, o_busy;
    logic [1:0]    o_id;

    int            n_checks;
    int            n_pass;
    logic [31:0]   exp_q[$];
    logic [7:0]    vec[$];

    int            rem[3];
    int            seq[3];
    int            plen[3];
    int            pkts[3];
    bit            gap0;

    stream_arbiter_rr #(.N_SRC(2), .DW(32), .MAX_BEATS(256)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data[63:0]),
        .s_valid_i (s_valid[1:0]),
        .s_last_i  (s_last[1:0]),
        .s_ready_o (a_ready),
        .m_data_o  (a_data),
        .m_valid_o (a_valid),
        .m_last_o  (a_last),
        .m_id_o    (a_id),
        .m_ready_i (m_ready),
        .busy_o    (a_busy)
    );

    stream_arbiter_rr #(.N_SRC(3), .DW(32), .MAX_BEATS(4)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_ready_o (b_ready),
        .m_data_o  (b_data),
        .m_valid_o (b_valid),
        .m_last_o  (b_last),
        .m_id_o    (b_id),
        .m_ready_i (m_ready),
        .busy_o    (b_busy)
    );

    always_comb begin
        if (sel) begin
            o_ready = b_ready;
            o_data  = b_data;
            o_valid = b_valid;
            o_last  = b_last;
            o_busy  = b_busy;
            o_id    = b_id;
        end else begin
            o_ready = {1'b0, a_ready};
            o_data  = a_data;
            o_valid = a_valid;
            o_last  = a_last;
            o_busy  = a_busy;
            o_id    = {1'b0, a_id};
        end
    end

    // Clock / reset block: reset itself is driven from the vectors.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_src(input int k, input int len, input int npk);
        plen[k] = len;
        pkts[k] = npk;
        rem[k]  = (npk > 0) ? len : 0;
        seq[k]  = 0;
    endtask

    task automatic push_exp(input int k, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(32'hA000_0000 | (32'(k) << 16) | 32'(first + i));
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            s_valid[k] = (rem[k] > 0) && !(k == 0 && gap0);
            s_last[k]  = (rem[k] == 1);
            s_data[k*32 +: 32] = 32'hA000_0000 | (32'(k) << 16) | 32'(seq[k]);
        end
    endtask

    // Handshakes seen before the edge complete at the edge.
    task automatic adv();
        logic [2:0] hs;
        hs = o_ready & s_valid;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (hs[k]) begin
                seq[k]++;
                rem[k]--;
                if (rem[k] == 0 && pkts[k] > 1) begin
                    pkts[k]--;
                    rem[k] = plen[k];
                end else if (rem[k] == 0) begin
                    pkts[k] = 0;
                end
            end
        end
        drive();
    endtask

    // Vector code per cycle: {gap0, rst, ready, busy, valid, last, id[1:0]}.
    task automatic run_vec(input string tag);
        logic [7:0] c;
        logic [2:0] er;
        for (int i = 0; i < vec.size(); i++) begin
            c       = vec[i];
            gap0    = c[7];
            rst     = c[6];
            m_ready = c[5];
            drive();
            @(negedge clk);
            er = (c[4] && c[5]) ? (3'b001 << c[1:0]) : 3'b000;
            check($sformatf("%s[%0d] busy", tag, i), 32'(o_busy), 32'(c[4]));
            check($sformatf("%s[%0d] valid", tag, i), 32'(o_valid), 32'(c[3]));
            check($sformatf("%s[%0d] last", tag, i), 32'(o_last), 32'(c[2]));
            check($sformatf("%s[%0d] s_ready", tag, i), 32'(o_ready), 32'(er));
            if (c[4]) begin
                check($sformatf("%s[%0d] id", tag, i), 32'(o_id), 32'(c[1:0]));
            end
            if (c[3] && c[5]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s[%0d] data (no expected beat)", tag, i), 32'(1), 32'(0));
                end else begin
                    check($sformatf("%s[%0d] data", tag, i), o_data, exp_q.pop_front());
                end
            end
            adv();
        end
        check($sformatf("%s beats left", tag), 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        m_ready  = 1'b0;
        gap0     = 1'b0;
        s_data   = '0;
        for (int k = 0; k < 3; k++) set_src(k, 0, 0);
        drive();

        // Two sources, 3-beat packets: 0 then 1 with one idle cycle between.
        sel = 1'b0;
        set_src(0, 3, 1);
        set_src(1, 3, 1);
        push_exp(0, 0, 3);
        push_exp(1, 0, 3);
        vec = '{8'h60, 8'h20, 8'h38, 8'h38, 8'h3C, 8'h20, 8'h39, 8'h39, 8'h3D, 8'h20};
        run_vec("two_src");

        // Three sources, single-beat packets: order 0,1,2,0,1,2.
        sel = 1'b1;
        for (int k = 0; k < 3; k++) set_src(k, 1, 2);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) push_exp(k, r, 1);
        end
        vec = '{8'h60, 8'h20, 8'h3C, 8'h20, 8'h3D, 8'h20, 8'h3E, 8'h20,
                8'h3C, 8'h20, 8'h3D, 8'h20, 8'h3E, 8'h20};
        run_vec("rr3");

        // Cap of 4 beats splits source 0's 10-beat packet around source 1.
        sel = 1'b1;
        set_src(0, 10, 1);
        set_src(1, 2, 3);
        set_src(2, 0, 0);
        push_exp(0, 0, 4);
        push_exp(1, 0, 2);
        push_exp(0, 4, 4);
        push_exp(1, 2, 2);
        push_exp(0, 8, 2);
        push_exp(1, 4, 2);
        vec = '{8'h60, 8'h20, 8'h38, 8'h38, 8'h38, 8'h3C, 8'h20, 8'h39, 8'h3D, 8'h20,
                8'h38, 8'h38, 8'h38, 8'h3C, 8'h20, 8'h39, 8'h3D, 8'h20,
                8'h38, 8'h3C, 8'h20, 8'h39, 8'h3D, 8'h20};
        run_vec("cap");

        // Granted source drops valid for 5 cycles; grant must hold on 0.
        sel = 1'b0;
        set_src(0, 4, 1);
        set_src(1, 2, 1);
        set_src(2, 0, 0);
        push_exp(0, 0, 4);
        push_exp(1, 0, 2);
        vec = '{8'h60, 8'h20, 8'h38, 8'h38, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90,
                8'h38, 8'h3C, 8'h20, 8'h39, 8'h3D, 8'h20};
        run_vec("gap");

        // Consumer ready toggles during a 3-beat grant.
        sel = 1'b0;
        set_src(0, 3, 1);
        set_src(1, 0, 0);
        push_exp(0, 0, 3);
        vec = '{8'h60, 8'h20, 8'h38, 8'h18, 8'h38, 8'h1C, 8'h3C, 8'h20};
        run_vec("ready_toggle");

        // Reset on beat 2 of 5: outputs drop at once, source 0 wins again.
        sel = 1'b0;
        set_src(0, 5, 1);
        set_src(1, 1, 1);
        push_exp(0, 0, 5);
        push_exp(1, 0, 1);
        vec = '{8'h60, 8'h20, 8'h38, 8'h60, 8'h20, 8'h38, 8'h38, 8'h38, 8'h3C,
                8'h20, 8'h3D, 8'h20};
        run_vec("mid_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
